// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes over a 128-bit state, LANES bytes per cycle.
// Captures one block, substitutes it group by group, then holds the result until it is taken.
module inv_sub_bytes #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [GW-1:0]   grp_reg;
  logic [127:0]    work_reg;
  logic [127:0]    work_next;
  logic [7:0]      sub_byte [LANES];

  // One table copy per lane, each reading the byte this group assigns to it.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [3:0] byte_idx;
    assign byte_idx     = 4'(32'(grp_reg) * LANES + gi);
    assign sub_byte[gi] = INV_SBOX[work_reg[{byte_idx, 3'b000} +: 8]];
  end

  always_comb begin
    work_next = work_reg;
    for (int l = 0; l < LANES; l++) begin
      work_next[{4'(32'(grp_reg) * LANES + l), 3'b000} +: 8] = sub_byte[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grp_reg   <= '0;
      work_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= state_in;
            grp_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          work_reg <= work_next;
          if (grp_reg == GW'(GROUPS - 1)) begin
            grp_reg   <= '0;
            state_reg <= DONE;
          end else begin
            grp_reg <= grp_reg + GW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == RUN) || (state_reg == DONE);
  assign state_out = work_reg;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes: one instance per legal LANES value, shared stimulus,
// expected data from an S-box model built out of GF(2^8) arithmetic.
module tb_inv_sub_bytes;

  localparam int NL = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] state_in;
  logic         out_ready;
  logic [NL-1:0] in_ready_v, out_valid_v, busy_v;
  logic [127:0] state_out_v [NL];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;
  vec_t vecs [20];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    inv_sub_bytes #(.LANES(1 << gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[gi]),
      .state_in  (state_in),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready),
      .state_out (state_out_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Forward S-box = affine map of the field inverse; the inverse table is its reverse lookup.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model_inv(logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!(&in_ready_v) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!(&in_ready_v)) check("idle_timeout", 128'(in_ready_v), 128'(5'h1f));
  endtask

  // Accept one block on every instance and check per-lane latency and data.
  task automatic run_block(logic [127:0] din, logic [127:0] exp, string name);
    int lat [NL];
    logic [127:0] got [NL];
    wait_idle();
    state_in = din;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = rand128();
    for (int l = 0; l < NL; l++) begin lat[l] = -1; got[l] = '0; end
    for (int k = 0; k < 18; k++) begin
      if (k == 0) check({name, "_busy"}, 128'({busy_v[0], in_ready_v[0]}), 128'(2'b10));
      for (int l = 0; l < NL; l++) begin
        if (lat[l] < 0 && out_valid_v[l]) begin
          lat[l] = k;
          got[l] = state_out_v[l];
        end
      end
      @(negedge clk);
    end
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s_lat_L%0d", name, 1 << l), 128'(lat[l]), 128'(16 >> l));
      check($sformatf("%s_data_L%0d", name, 1 << l), got[l], exp);
    end
    $display("block %s: in=%h out=%h", name, din, got[0]);
  endtask

  initial begin
    logic [127:0] a, b, exp_a;
    int t, r;
    int acc [$];
    logic [127:0] outs [$];

    build_model();
    vecs[0] = '{128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100, "fips"};
    vecs[1] = '{{16{8'h00}}, {16{8'h52}}, "all00"};
    vecs[2] = '{{16{8'h16}}, {16{8'hff}}, "all16"};
    vecs[3] = '{{16{8'h63}}, 128'h0, "all63"};
    for (int bk = 0; bk < 16; bk++) begin
      for (int i = 0; i < 16; i++) begin
        vecs[4 + bk].din[8*i +: 8]  = fwd_tab[bk * 16 + i];
        vecs[4 + bk].dout[8*i +: 8] = 8'(bk * 16 + i);
      end
      vecs[4 + bk].name = $sformatf("exh%0d", bk);
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = rand128();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 128'(in_ready_v), 128'(5'h1f));
    check("reset_valid", 128'({out_valid_v, busy_v}), 128'h0);
    check("reset_out", state_out_v[0] | state_out_v[4], 128'h0);

    for (int v = 0; v < 20; v++) run_block(vecs[v].din, vecs[v].dout, vecs[v].name);
    for (int v = 0; v < 8; v++) begin
      a = rand128();
      run_block(a, model_inv(a), $sformatf("rnd%0d", v));
    end

    // Back-pressure: result must hold in DONE while in_valid pulses are ignored.
    wait_idle();
    a = rand128(); exp_a = model_inv(a);
    state_in = a; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid_v[0] && t < 20) begin @(negedge clk); t++; end
    check("bp_reach_done", 128'(out_valid_v[0]), 128'h1);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp_hold%0d", j), 128'({out_valid_v[0], in_ready_v[0]}), 128'(2'b10));
      check($sformatf("bp_data%0d", j), state_out_v[0], exp_a);
      in_valid = (j % 2 == 0);
      state_in = rand128();
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 128'({out_valid_v[0], in_ready_v[0]}), 128'(2'b01));
    $display("backpressure: out=%h", exp_a);

    // Reset during RUN cycle 7 aborts the block.
    wait_idle();
    state_in = rand128(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_flags", 128'({out_valid_v[0], in_ready_v[0], busy_v[0]}), 128'(3'b010));
    check("abort_out", state_out_v[0], 128'h0);
    $display("abort: reset at run cycle 7");
    a = rand128();
    run_block(a, model_inv(a), "post_abort");

    // Back-to-back acceptances with in_valid and out_ready held high.
    wait_idle();
    a = rand128(); b = rand128();
    state_in = a; in_valid = 1'b1; out_ready = 1'b1;
    r = 0;
    while (outs.size() < 2 && r < 60) begin
      if (out_valid_v[0]) outs.push_back(state_out_v[0]);
      if (acc.size() >= 1) state_in = b;
      if (acc.size() >= 2) in_valid = 1'b0;
      if (in_ready_v[0] && in_valid) acc.push_back(r);
      @(negedge clk);
      r++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc.size()), 128'd2);
    check("b2b_spacing", 128'((acc.size() >= 2) ? acc[1] - acc[0] : -1), 128'd18);
    check("b2b_data0", (outs.size() > 0) ? outs[0] : 128'hx, model_inv(a));
    check("b2b_data1", (outs.size() > 1) ? outs[1] : 128'hx, model_inv(b));
    $display("back_to_back: %0d accepts, %0d results", acc.size(), outs.size());
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
